fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the pipelined MIPS CPU.
- Owns the PC and drives the instruction-memory address.
- Executes the stall/flush/redirect decisions produced by the hazard logic and the ID/EX control.
- Two performance counters track stall and flush activity.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset.
- ILLOP_ADDR, 32'h8000_0004, target for PCSrc=4 (illegal op / interrupt).
- XADR_ADDR, 32'h8000_0008, target for PCSrc=5 (exception).
- NOP_INSTR, 32'h0000_0000, bubble inserted into IF/ID on flush.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- PCWrite  in  1  0 = hold PC (load-use stall)
- IF_ID_write  in  1  0 = hold IF/ID register
- IF_ID_flush  in  1  1 = load bubble into IF/ID
- ID_PCSrc  in  3  PC source decoded in ID: 0 PC+4, 2 j/jal, 3 jr/jalr, 4 ILLOP, 5 XADR
- EX_PCSrc  in  3  PC source of the instruction in EX; value 1 = branch
- EX_ALUOut_0  in  1  branch condition result from EX
- EX_BranchTarget  in  32  branch target computed in EX
- ID_JrTarget  in  32  forwarded rs value for jr/jalr
- IMem_Addr  out  32  equals current PC
- IMem_Data  in  32  instruction at IMem_Addr, combinational read
- IF_ID_Instruction  out  32  registered instruction
- IF_ID_PC_plus_4  out  32  registered PC+4 of that instruction
- IF_ID_valid  out  1  0 = register holds a bubble
- stall_count  out  32  cycles stalled
- flush_count  out  32  bubbles inserted

Behaviour:
- Reset (sync, overrides everything, including mid-stall or mid-redirect):
  - PC = RESET_PC.
  - IF_ID_Instruction = NOP_INSTR, IF_ID_PC_plus_4 = 0, IF_ID_valid = 0.
  - Both counters = 0.
- Internal signals:
  - PC_plus_4 = PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - branch_taken = (EX_PCSrc == 1) && EX_ALUOut_0.
  - jump_target = {IF_ID_PC_plus_4[31:28], IF_ID_Instruction[25:0], 2'b00}.
- Next PC, first match wins:
  1. branch_taken -> EX_BranchTarget. PCWrite is ignored; the stalled consumer is younger and gets flushed.
  2. PCWrite == 0 -> hold PC.
  3. ID_PCSrc == 2 -> jump_target; 3 -> ID_JrTarget; 4 -> ILLOP_ADDR; 5 -> XADR_ADDR.
  4. Otherwise -> PC_plus_4. ID_PCSrc values 0, 1, 6 and 7 redirect nothing.
- IF/ID register update, first match wins:
  1. branch_taken -> bubble.
  2. IF_ID_write == 0 -> hold all three fields. IF_ID_flush is ignored, because the stalled jump re-evaluates next cycle.
  3. IF_ID_flush == 1 -> bubble.
  4. Otherwise -> load IMem_Data, PC_plus_4, valid = 1.
- Bubble contents: Instruction = NOP_INSTR, valid = 0, PC_plus_4 = PC_plus_4 of the squashed slot, kept for exception-EPC use.
- Latency: an instruction fetched at edge N is visible at the IF/ID outputs after edge N+1. A redirect is visible on IMem_Addr one cycle after it is presented.
- stall_count: +1 on every non-reset cycle with PCWrite == 0 && !branch_taken. Wraps at 2^32.
- flush_count: +1 on every non-reset cycle in which a bubble is loaded. Wraps at 2^32.
- Misaligned targets are passed through unchanged; no alignment check is performed.

Test Plan:
- Reset then 4 cycles idle (PCWrite=1, IF_ID_write=1, flush=0, PCSrc=0), IMem_Data = PC-derived -> IMem_Addr 8000_0000, _0004, _0008, _000C; IF_ID_PC_plus_4 lags by one cycle; valid=1 from the 2nd cycle.
- Load-use: PCWrite=0 and IF_ID_write=0 for 1 cycle at PC=8000_0010 -> PC and IF/ID held one cycle; stall_count=1; fetch resumes at 8000_0014.
- Branch taken: EX_PCSrc=1, EX_ALUOut_0=1, target 8000_0100, with PCWrite=0 in the same cycle -> PC=8000_0100; IF_ID_valid=0; IF_ID_Instruction=0; flush_count+1; stall_count unchanged.
- Jump: IF_ID_Instruction=0x0800_0040, IF_ID_PC_plus_4=8000_0024, ID_PCSrc=2, IF_ID_flush=1 -> PC=8000_0100; one bubble.
- jr under stall: ID_PCSrc=3, ID_JrTarget=0x0040_0000, PCWrite=0, IF_ID_write=0, IF_ID_flush=1 -> no redirect, IF/ID held. Next cycle with PCWrite=1 and IF_ID_write=1 -> PC=0x0040_0000 and a bubble is loaded.
- PCSrc=4 -> PC=8000_0004. PCSrc=5 -> PC=8000_0008. PC=FFFF_FFFC with no redirect -> next PC=0. Reset asserted during a stall -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage and IF/ID pipeline register for the
//            pipelined MIPS CPU. Owns the PC, drives the instruction-memory
//            address, applies stall / flush / redirect decisions, and keeps
//            stall and flush performance counters.
// Ports    : clk, reset (sync, active-high)
//            PCWrite, IF_ID_write, IF_ID_flush   - hazard-unit controls
//            ID_PCSrc, ID_JrTarget               - jump/exception redirects
//            EX_PCSrc, EX_ALUOut_0, EX_BranchTarget - branch resolution
//            IMem_Addr / IMem_Data               - instruction memory
//            IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_valid - IF/ID register
//            stall_count, flush_count            - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_write,
    input  logic        IF_ID_flush,
    input  logic [2:0]  ID_PCSrc,
    input  logic [2:0]  EX_PCSrc,
    input  logic        EX_ALUOut_0,
    input  logic [31:0] EX_BranchTarget,
    input  logic [31:0] ID_JrTarget,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_plus_4,
    output logic        IF_ID_valid,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    localparam logic [2:0] c_SRC_BRANCH = 3'd1;
    localparam logic [2:0] c_SRC_JUMP   = 3'd2;
    localparam logic [2:0] c_SRC_JR     = 3'd3;
    localparam logic [2:0] c_SRC_ILLOP  = 3'd4;
    localparam logic [2:0] c_SRC_XADR   = 3'd5;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus_4_q;
    logic        r_valid;
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    logic [31:0] w_pc_plus_4;
    logic        w_branch_taken;
    logic [31:0] w_jump_target;
    logic [31:0] w_next_pc;
    logic        w_stall;
    logic        w_bubble;

    assign w_pc_plus_4    = r_pc + 32'd4;   // natural wrap from 0xFFFF_FFFC to 0
    assign w_branch_taken = (EX_PCSrc == c_SRC_BRANCH) && EX_ALUOut_0;
    assign w_jump_target  = {r_pc_plus_4_q[31:28], r_instr[25:0], 2'b00};

    // A taken branch in EX is older than anything stalled behind it, so it
    // overrides the PC hold and squashes the IF/ID slot.
    assign w_stall  = !PCWrite && !w_branch_taken;
    // IF/ID hold beats flush: a stalled jump in ID re-issues its flush later.
    assign w_bubble = w_branch_taken || (IF_ID_write && IF_ID_flush);

    always_comb begin
        w_next_pc = w_pc_plus_4;
        if (w_branch_taken) begin
            w_next_pc = EX_BranchTarget;
        end else if (!PCWrite) begin
            w_next_pc = r_pc;
        end else begin
            case (ID_PCSrc)
                c_SRC_JUMP:  w_next_pc = w_jump_target;
                c_SRC_JR:    w_next_pc = ID_JrTarget;
                c_SRC_ILLOP: w_next_pc = ILLOP_ADDR;
                c_SRC_XADR:  w_next_pc = XADR_ADDR;
                default:     w_next_pc = w_pc_plus_4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_pc_plus_4_q <= 32'd0;
            r_valid       <= 1'b0;
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            r_pc <= w_next_pc;

            if (w_bubble) begin
                // Keep the squashed slot's PC+4 so an exception can form EPC.
                r_instr       <= NOP_INSTR;
                r_pc_plus_4_q <= w_pc_plus_4;
                r_valid       <= 1'b0;
            end else if (IF_ID_write) begin
                r_instr       <= IMem_Data;
                r_pc_plus_4_q <= w_pc_plus_4;
                r_valid       <= 1'b1;
            end

            if (w_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_bubble) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign IMem_Addr         = r_pc;
    assign IF_ID_Instruction = r_instr;
    assign IF_ID_PC_plus_4   = r_pc_plus_4_q;
    assign IF_ID_valid       = r_valid;
    assign stall_count       = r_stall_count;
    assign flush_count       = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A table of per-cycle
//            stimulus records with hand-derived expected outputs is replayed;
//            expectations are queued when a record is driven and popped and
//            compared just after the clock edge that produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    typedef struct {
        string       name;
        logic        rst;
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic [2:0]  idsrc;
        logic [2:0]  exsrc;
        logic        alu0;
        logic [31:0] btgt;
        logic [31:0] jrt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic [31:0] e_stall;
        logic [31:0] e_flush;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic [2:0]  ID_PCSrc;
    logic [2:0]  EX_PCSrc;
    logic        EX_ALUOut_0;
    logic [31:0] EX_BranchTarget;
    logic [31:0] ID_JrTarget;
    logic [31:0] IMem_Addr;
    logic [31:0] IMem_Data;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC_plus_4;
    logic        IF_ID_valid;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory: address-derived contents, with a j instruction
    // planted at 0x8000_0020 for the jump test.
    assign IMem_Data = (IMem_Addr == 32'h8000_0020) ? 32'h0800_0040
                                                    : (IMem_Addr ^ 32'h0F0F_0000);

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .PCWrite           (PCWrite),
        .IF_ID_write       (IF_ID_write),
        .IF_ID_flush       (IF_ID_flush),
        .ID_PCSrc          (ID_PCSrc),
        .EX_PCSrc          (EX_PCSrc),
        .EX_ALUOut_0       (EX_ALUOut_0),
        .EX_BranchTarget   (EX_BranchTarget),
        .ID_JrTarget       (ID_JrTarget),
        .IMem_Addr         (IMem_Addr),
        .IMem_Data         (IMem_Data),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC_plus_4   (IF_ID_PC_plus_4),
        .IF_ID_valid       (IF_ID_valid),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rst, input logic pcw,
                                input logic ifw, input logic fl, input logic [2:0] idsrc,
                                input logic [2:0] exsrc, input logic alu0,
                                input logic [31:0] btgt, input logic [31:0] jrt,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_pp4, input logic e_valid,
                                input logic [31:0] e_stall, input logic [31:0] e_flush);
        vec_t v;
        v.name = name; v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.fl = fl;
        v.idsrc = idsrc; v.exsrc = exsrc; v.alu0 = alu0; v.btgt = btgt; v.jrt = jrt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pp4 = e_pp4; v.e_valid = e_valid;
        v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    // Drive one record before the edge, queue its expectation, then compare
    // the registered outputs 1 ns after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset           = v.rst;
        PCWrite         = v.pcw;
        IF_ID_write     = v.ifw;
        IF_ID_flush     = v.fl;
        ID_PCSrc        = v.idsrc;
        EX_PCSrc        = v.exsrc;
        EX_ALUOut_0     = v.alu0;
        EX_BranchTarget = v.btgt;
        ID_JrTarget     = v.jrt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.name, ".pc"},    IMem_Addr,         e.e_pc);
            chk({e.name, ".instr"}, IF_ID_Instruction, e.e_instr);
            chk({e.name, ".pp4"},   IF_ID_PC_plus_4,   e.e_pp4);
            chk({e.name, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, e.e_valid});
            chk({e.name, ".stall"}, stall_count,       e.e_stall);
            chk({e.name, ".flush"}, flush_count,       e.e_flush);
        end
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b1; IF_ID_write = 1'b1; IF_ID_flush = 1'b0;
        ID_PCSrc = 3'd0; EX_PCSrc = 3'd0; EX_ALUOut_0 = 1'b0;
        EX_BranchTarget = 32'd0; ID_JrTarget = 32'd0;

        //             name        rst pcw ifw fl idsrc exsrc alu btgt           jr             pc             instr          pp4            v  stall flush
        vecs.push_back(mk("reset",   1, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk("idle1",   0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0004, 32'h8F0F_0000, 32'h8000_0004, 1, 0, 0));
        vecs.push_back(mk("idle2",   0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0008, 32'h8F0F_0004, 32'h8000_0008, 1, 0, 0));
        vecs.push_back(mk("idle3",   0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_000C, 32'h8F0F_0008, 32'h8000_000C, 1, 0, 0));
        vecs.push_back(mk("idle4",   0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0010, 32'h8F0F_000C, 32'h8000_0010, 1, 0, 0));
        vecs.push_back(mk("loaduse", 0, 0, 0, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0010, 32'h8F0F_000C, 32'h8000_0010, 1, 1, 0));
        vecs.push_back(mk("resume",  0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0014, 32'h8F0F_0010, 32'h8000_0014, 1, 1, 0));
        vecs.push_back(mk("br_tkn",  0, 0, 1, 0, 3'd0, 3'd1, 1, 32'h8000_0100, 32'h0,         32'h8000_0100, 32'h0000_0000, 32'h8000_0018, 0, 1, 1));
        vecs.push_back(mk("br_ntkn", 0, 1, 1, 0, 3'd0, 3'd1, 0, 32'h1234_5678, 32'h0,         32'h8000_0104, 32'h8F0F_0100, 32'h8000_0104, 1, 1, 1));
        vecs.push_back(mk("jr_go",   0, 1, 1, 0, 3'd3, 3'd0, 0, 32'h0,         32'h8000_0020, 32'h8000_0020, 32'h8F0F_0104, 32'h8000_0108, 1, 1, 1));
        vecs.push_back(mk("fetch_j", 0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0024, 32'h0800_0040, 32'h8000_0024, 1, 1, 1));
        vecs.push_back(mk("jump",    0, 1, 1, 1, 3'd2, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0100, 32'h0000_0000, 32'h8000_0028, 0, 1, 2));
        vecs.push_back(mk("jr_stl",  0, 0, 0, 1, 3'd3, 3'd0, 0, 32'h0,         32'h0040_0000, 32'h8000_0100, 32'h0000_0000, 32'h8000_0028, 0, 2, 2));
        vecs.push_back(mk("jr_rel",  0, 1, 1, 1, 3'd3, 3'd0, 0, 32'h0,         32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 32'h8000_0104, 0, 2, 3));
        vecs.push_back(mk("illop",   0, 1, 1, 0, 3'd4, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0004, 32'h0F4F_0000, 32'h0040_0004, 1, 2, 3));
        vecs.push_back(mk("xadr",    0, 1, 1, 0, 3'd5, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0008, 32'h8F0F_0004, 32'h8000_0008, 1, 2, 3));
        vecs.push_back(mk("br_top",  0, 1, 1, 0, 3'd0, 3'd1, 1, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h8000_000C, 0, 2, 4));
        vecs.push_back(mk("wrap",    0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h0000_0000, 32'hF0F0_FFFC, 32'h0000_0000, 1, 2, 4));
        vecs.push_back(mk("src6",    0, 1, 1, 0, 3'd6, 3'd0, 0, 32'h0,         32'h0,         32'h0000_0004, 32'h0F0F_0000, 32'h0000_0004, 1, 2, 4));
        vecs.push_back(mk("src1",    0, 1, 1, 0, 3'd1, 3'd0, 0, 32'h0,         32'h0,         32'h0000_0008, 32'h0F0F_0004, 32'h0000_0008, 1, 2, 4));
        vecs.push_back(mk("mis_jr",  0, 1, 1, 0, 3'd3, 3'd0, 0, 32'h0,         32'h0000_0102, 32'h0000_0102, 32'h0F0F_0008, 32'h0000_000C, 1, 2, 4));
        vecs.push_back(mk("stall_a", 0, 0, 0, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h0000_0102, 32'h0F0F_0008, 32'h0000_000C, 1, 3, 4));
        vecs.push_back(mk("rst_stl", 1, 0, 0, 1, 3'd2, 3'd1, 1, 32'h1111_1110, 32'h0,         32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk("post_rs", 0, 1, 1, 0, 3'd0, 3'd0, 0, 32'h0,         32'h0,         32'h8000_0004, 32'h8F0F_0000, 32'h8000_0004, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Hand-written corner: IF/ID held while PC advances, with a flush
        // request that must be ignored (no bubble, flush_count unchanged).
        @(negedge clk);
        PCWrite = 1'b1; IF_ID_write = 1'b0; IF_ID_flush = 1'b1;
        ID_PCSrc = 3'd0; EX_PCSrc = 3'd0; EX_ALUOut_0 = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_ifid.pc",    IMem_Addr,         32'h8000_0008);
        chk("hold_ifid.instr", IF_ID_Instruction, 32'h8F0F_0000);
        chk("hold_ifid.valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("hold_ifid.flush", flush_count,       32'd0);
        chk("hold_ifid.stall", stall_count,       32'd0);

        // Hand-written corner: three back-to-back stalls, then a taken
        // branch while still stalled (branch wins, not counted as stall).
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            PCWrite = 1'b0; IF_ID_write = 1'b0; IF_ID_flush = 1'b0;
            @(posedge clk);
            #1;
            chk("multi_stall.cnt", stall_count, k);
            chk("multi_stall.pc",  IMem_Addr,   32'h8000_0008);
        end
        @(negedge clk);
        EX_PCSrc = 3'd1; EX_ALUOut_0 = 1'b1; EX_BranchTarget = 32'h8000_0200;
        @(posedge clk);
        #1;
        chk("stall_br.pc",    IMem_Addr,   32'h8000_0200);
        chk("stall_br.stall", stall_count, 32'd3);
        chk("stall_br.flush", flush_count, 32'd1);
        chk("stall_br.pp4",   IF_ID_PC_plus_4, 32'h8000_000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
